// File: rtl/fb_bank_arbiter.sv
// fb_bank_arbiter
// ---------------
// Arbitrates a single-port, double-banked row framebuffer
// (2 banks x 2**ADDR_W rows x ROW_W bits) between two clients:
//   * the display row-fetch path, which reads the front bank with a
//     fixed latency, and
//   * the MCU/SPI frame writer, which fills the back bank.
// The banks swap only at a display frame boundary after the writer
// reports a finished frame, so a half-written frame is never shown.
//
// Optional build macro: FB_CLEAR_EN
//   Defined   : after every swap the new back bank is cleared to zero,
//               one row per cycle. Pending display reads pre-empt the clear.
//   Undefined : no clear. The back bank keeps its stale contents.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   disp_rd_req     1-cycle pulse, display requests row disp_rd_addr
//   disp_rd_valid   1-cycle pulse, disp_rd_data holds the requested row
//   frame_end       pulse, display finished fetching a frame
//   wr_valid/ready  writer handshake for (wr_addr, wr_data)
//   wr_frame_done   pulse, writer finished the back bank
//   swap_pending    frame done, waiting for frame_end
//   front_bank      bank currently displayed
//   rd_overrun      sticky, a display request was dropped
//   mem_*           single-port RAM interface, mem_addr = {bank, row}
//   state_dbg       current FSM state encoding
//
// Handshake: a write row transfers in every cycle where wr_valid and
// wr_ready are both high. wr_ready does not depend on wr_valid. The writer
// holds wr_addr/wr_data stable while wr_valid is high and not yet accepted.

module fb_bank_arbiter #(
    parameter int ROW_W  = 64,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_rd_req,
    input  logic [ADDR_W-1:0] disp_rd_addr,
    output logic              disp_rd_valid,
    output logic [ROW_W-1:0]  disp_rd_data,
    input  logic              frame_end,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ROW_W-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              wr_frame_done,
    output logic              swap_pending,
    output logic              front_bank,
    output logic              rd_overrun,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [ROW_W-1:0]  mem_wdata,
    input  logic [ROW_W-1:0]  mem_rdata,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        SWAP     = 3'd4
`ifdef FB_CLEAR_EN
        , CLEAR  = 3'd5
`endif
    } state_t;

    state_t            state, state_nxt;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              swap_arm;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ROW_W-1:0]  wr_data_q;
    logic [1:0]        wait_cnt;
    logic              rd_last;
    logic              wr_fire;
`ifdef FB_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_resume;   // a read pre-empted the clear
`endif

    assign state_dbg = state;
    assign rd_last   = (wait_cnt == 2'(RD_LAT - 1));
    assign wr_fire   = wr_valid & wr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (swap_arm)     state_nxt = SWAP;
                else if (rd_pend) state_nxt = RD_ISSUE;
                else if (wr_fire) state_nxt = WR_ISSUE;
            end
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (rd_last) begin
`ifdef FB_CLEAR_EN
                    state_nxt = clr_resume ? CLEAR : IDLE;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            WR_ISSUE: state_nxt = IDLE;
`ifdef FB_CLEAR_EN
            SWAP: state_nxt = CLEAR;
            CLEAR: begin
                if (rd_pend)             state_nxt = RD_ISSUE;
                else if (clr_cnt == '1)  state_nxt = IDLE;
            end
`else
            SWAP: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: RAM port and writer ready
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            RD_ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = {front_bank, rd_addr_q};
            end
            WR_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {~front_bank, wr_addr_q};
                mem_wdata = wr_data_q;
            end
`ifdef FB_CLEAR_EN
            CLEAR: begin
                // the cycle a read is pending is handed to the read
                if (!rd_pend) begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = {~front_bank, clr_cnt};
                end
            end
`endif
            default: ;
        endcase
        // a same-cycle display request blocks the write so reads win the port
        wr_ready = !reset && (state == IDLE) && !rd_pend && !disp_rd_req
                   && !swap_pending;
    end

    // Datapath and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend       <= 1'b0;
            rd_addr_q     <= '0;
            rd_overrun    <= 1'b0;
            swap_pending  <= 1'b0;
            swap_arm      <= 1'b0;
            front_bank    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wait_cnt      <= '0;
            disp_rd_valid <= 1'b0;
            disp_rd_data  <= '0;
`ifdef FB_CLEAR_EN
            clr_cnt       <= '0;
            clr_resume    <= 1'b0;
`endif
        end else begin
            // only one read may be outstanding; extras are dropped and flagged
            if (disp_rd_req) begin
                if (rd_pend) begin
                    rd_overrun <= 1'b1;
                end else begin
                    rd_pend   <= 1'b1;
                    rd_addr_q <= disp_rd_addr;
                end
            end
            if (state == RD_ISSUE) rd_pend <= 1'b0;

            // frame_end only arms a swap whose frame_done arrived earlier
            if (wr_frame_done && !swap_pending) swap_pending <= 1'b1;
            if (frame_end && swap_pending)      swap_arm     <= 1'b1;
            if (state == SWAP) begin
                front_bank   <= ~front_bank;
                swap_pending <= 1'b0;
                swap_arm     <= 1'b0;
            end

            if (wr_fire) begin
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
            end

            if (state == RD_ISSUE)     wait_cnt <= '0;
            else if (state == RD_WAIT) wait_cnt <= wait_cnt + 2'd1;

            disp_rd_valid <= (state == RD_WAIT) && rd_last;
            if ((state == RD_WAIT) && rd_last) disp_rd_data <= mem_rdata;

`ifdef FB_CLEAR_EN
            if (state == SWAP) clr_cnt <= '0;
            else if (state == CLEAR && !rd_pend) clr_cnt <= clr_cnt + 1'b1;
            if (state == CLEAR && rd_pend)         clr_resume <= 1'b1;
            else if (state == RD_WAIT && rd_last)  clr_resume <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_fb_bank_arbiter.sv
// Self-checking bench for fb_bank_arbiter (RD_LAT = 1). Also covers the
// clear-after-swap behaviour when built with FB_CLEAR_EN.

module tb_fb_bank_arbiter;

    localparam int ROW_W  = 64;
    localparam int ADDR_W = 6;
    localparam int RD_LAT = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              disp_rd_req;
    logic [ADDR_W-1:0] disp_rd_addr;
    logic              disp_rd_valid;
    logic [ROW_W-1:0]  disp_rd_data;
    logic              frame_end;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [ROW_W-1:0]  wr_data;
    logic              wr_ready;
    logic              wr_frame_done;
    logic              swap_pending;
    logic              front_bank;
    logic              rd_overrun;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [ROW_W-1:0]  mem_wdata;
    logic [ROW_W-1:0]  mem_rdata;
    logic [2:0]        state_dbg;

    fb_bank_arbiter #(.ROW_W(ROW_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .disp_rd_req(disp_rd_req), .disp_rd_addr(disp_rd_addr),
        .disp_rd_valid(disp_rd_valid), .disp_rd_data(disp_rd_data),
        .frame_end(frame_end),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_frame_done(wr_frame_done),
        .swap_pending(swap_pending), .front_bank(front_bank),
        .rd_overrun(rd_overrun),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .state_dbg(state_dbg)
    );

    // ---------------- RAM model (1-cycle read latency) ----------------
    function automatic logic [ROW_W-1:0] init_val(input int idx);
        logic [7:0] b;
        b = 8'(idx) ^ 8'h3C;
        if (idx == 5) return 64'hA5A5_A5A5_A5A5_A5A5;
        return {8{b}};
    endfunction

    logic [ROW_W-1:0] ram [0:127];
    logic             ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    logic [ROW_W-1:0]        exp_q[$];      // expected read rows
    int                      exp_cyc_q[$];  // expected disp_rd_valid cycle
    logic [ADDR_W+ROW_W:0]   wr_exp_q[$];   // expected {mem_addr, mem_wdata}
    logic [ROW_W-1:0]        ref_mem [0:127];
    logic                    exp_front;
    int                      clr_seen;
    int                      n_checks = 0;
    int                      n_errors = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && !ram_init) begin
            if (disp_rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_spurious", 1, 0);
                end else begin
                    check("rd_data", disp_rd_data, exp_q.pop_front());
                    check("rd_latency", cyc, exp_cyc_q.pop_front());
                end
            end
            if (mem_en && !mem_we) check("rd_bank", mem_addr[ADDR_W], exp_front);
            if (mem_en && mem_we) begin
                check("wr_bank", mem_addr[ADDR_W], !exp_front);
                if (wr_exp_q.size() != 0) begin
                    check("wr_addr_data", {mem_addr, mem_wdata}, wr_exp_q.pop_front());
                end else begin
`ifdef FB_CLEAR_EN
                    check("clr_row", mem_addr[ADDR_W-1:0], clr_seen[5:0]);
                    check("clr_data", mem_wdata, 0);
                    clr_seen++;
`else
                    check("wr_spurious", 1, 0);
`endif
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one read pulse; called just after a rising edge
    task automatic drive_read(input logic [ADDR_W-1:0] a, input int lat);
        disp_rd_req  = 1'b1;
        disp_rd_addr = a;
        exp_q.push_back(ref_mem[{exp_front, a}]);
        exp_cyc_q.push_back(cyc + lat);
        tick();
        disp_rd_req = 1'b0;
    endtask

    // hold wr_valid until accepted (bounded); returns the accept cycle
    task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [ROW_W-1:0] d,
                               output int acc_cyc);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (!done && n < 200) begin
            @(negedge clk);
            if (wr_ready) done = 1'b1;
            else n++;
        end
        if (!done) begin
            check("wr_timeout", 0, 1);
            acc_cyc = -1;
        end else begin
            acc_cyc = cyc;
            wr_exp_q.push_back({!exp_front, a, d});
            ref_mem[{!exp_front, a}] = d;
        end
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int a1, a2, n, acc;
        logic [ROW_W-1:0] d;
        logic [ADDR_W-1:0] ra;

        reset = 1'b1; ram_init = 1'b1;
        disp_rd_req = 0; disp_rd_addr = '0; frame_end = 0;
        wr_valid = 0; wr_addr = '0; wr_data = '0; wr_frame_done = 0;
        exp_front = 1'b0; clr_seen = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        repeat (3) tick();
        ram_init = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_front", front_bank, 0);
        check("rst_swap_pending", swap_pending, 0);
        check("rst_overrun", rd_overrun, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rd_valid", disp_rd_valid, 0);
        check("rst_rd_data", disp_rd_data, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_state", state_dbg, 0);
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("idle_wr_ready", wr_ready, 1);
        tick();

        // idle read of row 5: valid 4 cycles after request, data A5A5...
        drive_read(6'd5, 3 + RD_LAT);
        repeat (6) tick();

        // back-to-back writes, wr_valid held: accepts two cycles apart
        drive_write(6'd7, 64'h1234, a1);
        drive_write(6'd8, {$urandom, $urandom}, a2);
        check("wr_spacing", a2 - a1, 2);
        repeat (3) tick();

        // read and write in the same cycle: read first, write after it
        d = {$urandom, $urandom};
        n = cyc;
        disp_rd_req = 1'b1; disp_rd_addr = 6'd9;
        exp_q.push_back(ref_mem[{exp_front, 6'd9}]);
        exp_cyc_q.push_back(n + 3 + RD_LAT);
        wr_valid = 1'b1; wr_addr = 6'd3; wr_data = d;
        @(negedge clk);
        check("wr_ready_vs_rd_req", wr_ready, 0);
        tick();
        disp_rd_req = 1'b0;
        drive_write(6'd3, d, acc);
        check("wr_after_rd", acc, n + 3 + RD_LAT);
        repeat (3) tick();

        // frame_end without a finished frame does nothing
        frame_end = 1'b1; tick(); frame_end = 1'b0; tick();
        @(negedge clk);
        check("lone_frame_end_front", front_bank, 0);
        check("lone_frame_end_pending", swap_pending, 0);
        tick();

        // frame_done and frame_end together: swap waits for the next frame_end
        wr_frame_done = 1'b1; frame_end = 1'b1; tick();
        wr_frame_done = 1'b0; frame_end = 1'b0;
        @(negedge clk);
        check("swap_pending_set", swap_pending, 1);
        tick();
        wr_valid = 1'b1; wr_addr = 6'd1; wr_data = 64'hDEAD;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("wr_blocked_pending", wr_ready, 0);
            tick();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        check("front_held", front_bank, 0);
        tick();

        n = cyc;
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        tick();
        @(negedge clk);
        check("front_before_swap", front_bank, 0);
        tick();
        exp_front = 1'b1;
        @(negedge clk);
        check("front_after_swap", front_bank, 1);
        check("swap_cycle", cyc, n + 3);
        check("pending_cleared", swap_pending, 0);
        tick();

`ifdef FB_CLEAR_EN
        n = 0;
        while (clr_seen < 20 && n < 100) begin @(negedge clk); n++; end
        check("clr_reach_20", clr_seen >= 20, 1);
        check("wr_ready_clear", wr_ready, 0);
        tick();
        drive_read(6'd11, 3 + RD_LAT);
        n = 0;
        while (clr_seen < 64 && n < 200) begin @(negedge clk); n++; end
        repeat (3) tick();
        check("clr_total", clr_seen, 64);
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
`endif

        // write to row 0 now lands in bank 0 (mem_addr 0x00)
        d = {$urandom, $urandom};
        drive_write(6'd0, d, acc);
        repeat (3) tick();
        // row 7 of the new front bank holds the earlier write
        drive_read(6'd7, 3 + RD_LAT);
        repeat (6) tick();

        // random reads from the front bank
        for (int i = 0; i < 6; i++) begin
            ra = 6'($urandom_range(0, 63));
            drive_read(ra, 3 + RD_LAT);
            repeat (5) tick();
        end

        // two requests while a write issues: first serviced, second dropped
        drive_write(6'd12, {$urandom, $urandom}, acc);
        drive_read(6'd2, 3 + RD_LAT);
        disp_rd_req = 1'b1; disp_rd_addr = 6'd4;
        tick();
        disp_rd_req = 1'b0;
        @(negedge clk);
        check("overrun_set", rd_overrun, 1);
        repeat (8) tick();
        @(negedge clk);
        check("overrun_sticky", rd_overrun, 1);
        tick();

        // reset during RD_WAIT: no valid afterwards, state back to reset
        disp_rd_req = 1'b1; disp_rd_addr = 6'd6;
        tick();
        disp_rd_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_front = 1'b0;
        @(negedge clk);
        check("post_rst_front", front_bank, 0);
        check("post_rst_overrun", rd_overrun, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", disp_rd_valid, 0);
            tick();
        end

        check("rd_queue_empty", exp_q.size(), 0);
        check("wr_queue_empty", wr_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fb_bank_arbiter.md
Name: fb_bank_arbiter

Overview:
Owns the single-port, double-banked row framebuffer (2 banks x 64 rows x 64 bits) between the display row-fetch path and the MCU/SPI frame writer. The display reads rows from the front bank with fixed latency. The writer fills the back bank through a valid/ready handshake. Banks are swapped only at a display frame boundary after the writer signals frame completion, so a half-written frame is never shown.

Parameters:
ROW_W, 64, bits per framebuffer row word
ADDR_W, 6, row address width (64 rows per bank)
RD_LAT, 1, RAM read latency in cycles (1 or 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
disp_rd_req  in  1  single-cycle pulse: display requests one row
disp_rd_addr  in  ADDR_W  row address, sampled with disp_rd_req
disp_rd_valid  out  1  one-cycle pulse: disp_rd_data is valid
disp_rd_data  out  ROW_W  registered read row
frame_end  in  1  pulse from display FSM after the last row of a frame is fetched
wr_valid  in  1  writer has a row to write
wr_addr  in  ADDR_W  writer row address
wr_data  in  ROW_W  writer row data
wr_ready  out  1  arbiter accepts the write this cycle
wr_frame_done  in  1  pulse: writer finished the back bank
swap_pending  out  1  frame done, waiting for frame_end
front_bank  out  1  bank currently displayed
rd_overrun  out  1  sticky: a read request was dropped
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W+1  {bank, row}
mem_wdata  out  ROW_W  RAM write data
mem_rdata  in  ROW_W  RAM read data, valid RD_LAT cycles after mem_en & !mem_we

Behaviour:
- Reset values:
  - state = IDLE.
  - front_bank, swap_pending, rd_overrun = 0.
  - mem_en, mem_we, disp_rd_valid, wr_ready = 0.
  - mem_addr, mem_wdata, disp_rd_data = 0.
  - Internal flags rd_pend, swap_arm = 0.
- Reset mid-operation aborts any access. In-flight read data is discarded and no disp_rd_valid is issued.
- Read request capture:
  - disp_rd_req sets rd_pend and latches the address.
  - A request arriving while rd_pend=1 is dropped and sets rd_overrun (cleared only by reset).
- wr_frame_done sets swap_pending. It is ignored if swap_pending is already 1.
- frame_end with swap_pending=1 sets swap_arm.
  - frame_end with swap_pending=0 has no effect.
  - wr_frame_done and frame_end in the same cycle: the swap waits for the next frame_end.
- wr_ready = (state==IDLE) & !rd_pend & !disp_rd_req & !swap_pending. It is combinational from registered state plus disp_rd_req.
- A write transfer occurs when wr_valid & wr_ready.
- IDLE priority: swap_arm > rd_pend > write.
- States:
  - IDLE:
    - swap_arm -> SWAP.
    - Else rd_pend -> RD_ISSUE.
    - Else write transfer -> WR_ISSUE, capturing addr and data.
  - RD_ISSUE: mem_en=1, mem_we=0, mem_addr={front_bank, latched addr}. Clear rd_pend. -> RD_WAIT.
  - RD_WAIT: stay RD_LAT cycles. On the last cycle, register mem_rdata into disp_rd_data and pulse disp_rd_valid the following cycle. -> IDLE.
  - WR_ISSUE: mem_en=1, mem_we=1, mem_addr={~front_bank, wr_addr}, mem_wdata=wr_data. -> IDLE.
  - SWAP: toggle front_bank, clear swap_pending and swap_arm. -> IDLE (or CLEAR, see Optional Feature).
- Read latency from disp_rd_req to disp_rd_valid:
  - Idle arbiter: exactly 3+RD_LAT cycles.
  - Worst case (write or swap in progress): 4+RD_LAT cycles without FB_CLEAR_EN.
- mem_en is 0 in IDLE and SWAP.
- A write can never target the front bank.
- A read can never target the back bank.

Optional Feature:
FB_CLEAR_EN:
- Defined: SWAP -> CLEAR. CLEAR writes zeros to all 64 rows of the new back bank, one row per cycle, using an internal 6-bit counter.
  - If rd_pend is set, CLEAR yields one RD_ISSUE/RD_WAIT sequence, then resumes at the same counter value.
  - wr_ready = 0 throughout CLEAR.
  - CLEAR -> IDLE after row 63 is written.
  - Read latency bound is unchanged; write stall is at most 64 + reads cycles.
- Not defined: the CLEAR state and its counter are absent, SWAP -> IDLE, and the back bank retains stale contents.

Test Plan:
- Reset, idle, then disp_rd_req addr=5 with RAM bank0 row5=0xA5A5... -> mem_addr=0x05 read, disp_rd_valid exactly 4 cycles after req (RD_LAT=1), data 0xA5A5....
- wr_valid held, addr=7, data=0x1234 -> wr_ready high, mem_we with mem_addr=0x47 (bank1), next write accepted two cycles later.
- disp_rd_req and wr_valid in the same cycle -> read serviced first, wr_ready=0 that cycle, write issued after the read completes.
- wr_frame_done, then 3 writes attempted, then frame_end -> wr_ready=0 while swap_pending, front_bank 0->1 one cycle after IDLE sees swap_arm, then a write to addr 0 hits mem_addr=0x00.
- Two disp_rd_req pulses 1 cycle apart while a write is issuing -> first serviced, second dropped, rd_overrun=1 until reset; reset mid-RD_WAIT -> no disp_rd_valid, front_bank=0.
- With FB_CLEAR_EN: swap, then disp_rd_req during clear row 20 -> read returned within 5 cycles, clear resumes at row 20, 64 zero-writes to bank0 total, wr_ready returns high afterwards.
